// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and stage-latch controls shared between the datapath
// (master) and the pipeline control unit (slave).
interface pipeline_ctrl_if;
  logic        ihit;
  logic        dhit;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic        ex_dREN;
  logic [4:0]  ex_wsel;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_pc_redirect;
  logic        mem_halt;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        exmem_flush;
  logic        memwb_en;
  logic        memwb_flush;
  logic        halt_o;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
           id_uses_rt, ex_pc_redirect, mem_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, memwb_flush, halt_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
           id_uses_rt, ex_pc_redirect, mem_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, memwb_flush, halt_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: resolves cache waits, load-use, redirects and halt
// into en/flush controls for every stage latch plus the PC enable.
module pipeline_ctrl (
  input  logic           CLK,
  input  logic           nRST,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic        memwait_s, loaduse_s, redirect_s;
  logic        pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic        exmem_en_s, exmem_flush_s, memwb_en_s, memwb_flush_s;
  logic [15:0] stall_cnt_r, flush_cnt_r;

  assign memwait_s = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
  assign loaduse_s = bus.ex_dREN & (bus.ex_wsel != 5'd0) &
                     ((bus.ex_wsel == bus.id_rs) |
                      (bus.id_uses_rt & (bus.ex_wsel == bus.id_rt)));

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and latch-control decode, highest-priority hazard first
  always_comb begin
    next_state_s  = RUN;
    redirect_s    = 1'b0;
    pc_en_s       = 1'b0;
    ifid_en_s     = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_en_s    = 1'b0;
    exmem_flush_s = 1'b0;
    memwb_en_s    = 1'b0;
    memwb_flush_s = 1'b0;
    case (state_r)
      RUN, DWAIT: begin
        if (bus.mem_halt) begin
          // Let the halt itself retire into WB, freeze everything upstream
          memwb_en_s   = 1'b1;
          next_state_s = HALTED;
        end else if (memwait_s) begin
          memwb_flush_s = 1'b1;
          next_state_s  = DWAIT;
        end else if (bus.ex_pc_redirect) begin
          redirect_s   = 1'b1;
          pc_en_s      = 1'b1;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          exmem_en_s   = 1'b1;
          memwb_en_s   = 1'b1;
        end else if (loaduse_s) begin
          idex_flush_s = 1'b1;
          exmem_en_s   = 1'b1;
          memwb_en_s   = 1'b1;
        end else if (!bus.ihit) begin
          ifid_flush_s = 1'b1;
          idex_en_s    = 1'b1;
          exmem_en_s   = 1'b1;
          memwb_en_s   = 1'b1;
        end else begin
          pc_en_s    = 1'b1;
          ifid_en_s  = 1'b1;
          idex_en_s  = 1'b1;
          exmem_en_s = 1'b1;
          memwb_en_s = 1'b1;
        end
      end
      HALTED: begin
        next_state_s = HALTED;
      end
      default: begin
        next_state_s = RUN;
      end
    endcase
  end

  // Saturating stall and redirect-flush counters, frozen once halted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if ((state_r != HALTED) && !pc_en_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (redirect_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  // Controls are Mealy but must read as zero while reset is held
  assign bus.pc_en       = nRST & pc_en_s;
  assign bus.ifid_en     = nRST & ifid_en_s;
  assign bus.ifid_flush  = nRST & ifid_flush_s;
  assign bus.idex_en     = nRST & idex_en_s;
  assign bus.idex_flush  = nRST & idex_flush_s;
  assign bus.exmem_en    = nRST & exmem_en_s;
  assign bus.exmem_flush = nRST & exmem_flush_s;
  assign bus.memwb_en    = nRST & memwb_en_s;
  assign bus.memwb_flush = nRST & memwb_flush_s;
  assign bus.halt_o      = nRST & (state_r == HALTED);
  assign bus.stall_cnt   = stall_cnt_r;
  assign bus.flush_cnt   = flush_cnt_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipeline_ctrl;
  logic CLK = 1'b0;
  logic nRST = 1'b0;

  pipeline_ctrl_if bus();

  pipeline_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //        exmem_en, exmem_flush, memwb_en, memwb_flush}
  localparam logic [8:0] ZERO  = 9'b000000000;
  localparam logic [8:0] FULL  = 9'b110101010;
  localparam logic [8:0] LU    = 9'b000011010;
  localparam logic [8:0] MW    = 9'b000000001;
  localparam logic [8:0] RD    = 9'b101011010;
  localparam logic [8:0] IMISS = 9'b001101010;
  localparam logic [8:0] HLT   = 9'b000000010;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic        halt;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [8:0] act_ctl();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
            bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};
  endfunction

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (act_ctl() !== e.ctl || bus.halt_o !== e.halt ||
          bus.stall_cnt !== e.stall || bus.flush_cnt !== e.flush) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b halt=%b stall=%h flush=%h, expected ctl=%b halt=%b stall=%h flush=%h",
                 e.name, act_ctl(), bus.halt_o, bus.stall_cnt, bus.flush_cnt,
                 e.ctl, e.halt, e.stall, e.flush);
      end
    end
  end

  task automatic idle_inputs();
    bus.ihit           = 1'b1;
    bus.dhit           = 1'b0;
    bus.mem_dREN       = 1'b0;
    bus.mem_dWEN       = 1'b0;
    bus.ex_dREN        = 1'b0;
    bus.ex_wsel        = 5'd0;
    bus.id_rs          = 5'd0;
    bus.id_rt          = 5'd0;
    bus.id_uses_rt     = 1'b0;
    bus.ex_pc_redirect = 1'b0;
    bus.mem_halt       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic expect_vec(input string name, input logic [8:0] ctl,
                            input logic halt, input logic [15:0] s,
                            input logic [15:0] f);
    exp_t e;
    e.name = name; e.ctl = ctl; e.halt = halt; e.stall = s; e.flush = f;
    exp_q.push_back(e);
  endtask

  initial begin
    idle_inputs();
    // Reset held: everything zero even though ihit=1
    next_cycle(); expect_vec("reset0", ZERO, 1'b0, 16'd0, 16'd0);
    next_cycle(); expect_vec("reset1", ZERO, 1'b0, 16'd0, 16'd0);
    next_cycle(); nRST = 1'b1; expect_vec("run_full", FULL, 1'b0, 16'd0, 16'd0);

    next_cycle(); bus.ex_dREN = 1'b1; bus.ex_wsel = 5'd5; bus.id_rs = 5'd5;
    expect_vec("loaduse_rs", LU, 1'b0, 16'd0, 16'd0);
    next_cycle(); expect_vec("after_lu", FULL, 1'b0, 16'd1, 16'd0);
    next_cycle(); bus.ex_dREN = 1'b1; bus.ex_wsel = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    expect_vec("loaduse_rt", LU, 1'b0, 16'd1, 16'd0);
    next_cycle(); bus.ex_dREN = 1'b1; bus.ex_wsel = 5'd7; bus.id_rt = 5'd7;
    expect_vec("rt_unused", FULL, 1'b0, 16'd2, 16'd0);
    next_cycle(); bus.ex_dREN = 1'b1;
    expect_vec("wsel_zero", FULL, 1'b0, 16'd2, 16'd0);
    next_cycle(); bus.ihit = 1'b0;
    expect_vec("imiss", IMISS, 1'b0, 16'd2, 16'd0);

    for (int i = 0; i < 3; i++) begin
      next_cycle(); bus.mem_dREN = 1'b1;
      expect_vec("dwait", MW, 1'b0, 16'(3 + i), 16'd0);
    end
    next_cycle(); bus.mem_dREN = 1'b1; bus.dhit = 1'b1;
    expect_vec("dhit_adv", FULL, 1'b0, 16'd6, 16'd0);

    next_cycle(); bus.ex_pc_redirect = 1'b1; bus.ex_dREN = 1'b1;
    bus.ex_wsel = 5'd5; bus.id_rs = 5'd5; bus.ihit = 1'b0;
    expect_vec("redir_combo", RD, 1'b0, 16'd6, 16'd0);
    next_cycle(); expect_vec("after_redir", FULL, 1'b0, 16'd6, 16'd1);

    next_cycle(); bus.mem_dWEN = 1'b1; bus.ex_pc_redirect = 1'b1;
    expect_vec("memwait_redir", MW, 1'b0, 16'd6, 16'd1);
    next_cycle(); bus.mem_dWEN = 1'b1; bus.dhit = 1'b1; bus.ex_pc_redirect = 1'b1;
    expect_vec("dhit_redir", RD, 1'b0, 16'd7, 16'd1);
    next_cycle(); expect_vec("after_redir2", FULL, 1'b0, 16'd7, 16'd2);

    next_cycle(); bus.mem_halt = 1'b1; bus.mem_dREN = 1'b1;
    expect_vec("halt_memwait", HLT, 1'b0, 16'd7, 16'd2);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      bus.ihit = 1'($urandom); bus.dhit = 1'($urandom);
      bus.mem_dREN = 1'($urandom); bus.mem_dWEN = 1'($urandom);
      bus.ex_dREN = 1'($urandom); bus.ex_wsel = 5'($urandom);
      bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
      bus.id_uses_rt = 1'($urandom); bus.ex_pc_redirect = 1'($urandom);
      bus.mem_halt = 1'($urandom);
      expect_vec("halted", ZERO, 1'b1, 16'd8, 16'd2);
    end
    next_cycle(); nRST = 1'b0;
    expect_vec("reset_halted", ZERO, 1'b0, 16'd0, 16'd0);
    next_cycle(); nRST = 1'b1;
    expect_vec("rerun", FULL, 1'b0, 16'd0, 16'd0);

    for (int i = 0; i < 70000; i++) begin
      next_cycle(); bus.ihit = 1'b0;
    end
    expect_vec("sat_stall", IMISS, 1'b0, 16'hFFFF, 16'd0);
    next_cycle(); bus.ihit = 1'b0;
    expect_vec("sat_hold", IMISS, 1'b0, 16'hFFFF, 16'd0);

    @(posedge CLK);
    @(posedge CLK);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control unit for the 5-stage core. It drives the `en`/`flush` pair of every stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves I-cache misses, D-cache waits, load-use hazards, taken branches/jumps and halt. It sits beside the datapath and is the sole driver of the latch control inputs. All latches load when `en`=1, clear when `en`=0 and `flush`=1, and hold otherwise, so this block never asserts `en` and `flush` together for the same latch.

## Interface
- No parameters.
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_dREN, mem_dWEN  in  1 each  memory op held in MEM stage
- ex_dREN  in  1  instruction in EX is a load
- ex_wsel  in  5  destination register of instruction in EX
- id_rs, id_rt  in  5 each  source registers of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_pc_redirect  in  1  taken branch or jump resolved in EX
- mem_halt  in  1  halt instruction in MEM
- pc_en  out  1  PC register load
- ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  latch controls
- halt_o  out  1  core halted (sticky)
- stall_cnt  out  16  cycles with pc_en=0 while not halted
- flush_cnt  out  16  redirect flush events

## Operation
- FSM states: RUN, DWAIT, HALTED. Reset state is RUN.
- Outputs are combinational from state and inputs (Mealy). Counters and state are registered.
- Conditions:
  - memwait = (mem_dREN|mem_dWEN) & !dhit
  - loaduse = ex_dREN & ex_wsel≠0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt))
- Priority when in RUN or DWAIT, highest first:
  1. mem_halt: memwb_en=1; all other en=0; all flush=0; pc_en=0. Next state is HALTED.
  2. memwait: all en=0; memwb_flush=1; other flush=0; pc_en=0. Next state is DWAIT.
  3. ex_pc_redirect: pc_en=1; ifid_flush=1; idex_flush=1; ifid_en=idex_en=0; exmem_en=memwb_en=1. flush_cnt increments.
  4. loaduse: pc_en=0; ifid_en=0; idex_flush=1; idex_en=0; exmem_en=memwb_en=1.
  5. !ihit: pc_en=0; ifid_flush=1; ifid_en=0; idex_en=exmem_en=memwb_en=1.
  6. Otherwise: pc_en and all en=1; all flush=0.
- Unless rule 1 or 2 fires, next state is RUN. DWAIT therefore exits in the cycle dhit arrives, and that cycle evaluates rules 3–6.
- HALTED: all en, flush and pc_en are 0; halt_o=1; counters frozen. Only nRST exits this state.
- halt_o = (state==HALTED). It rises the cycle after mem_halt is sampled.
- stall_cnt increments on each clock edge where state≠HALTED and pc_en=0. flush_cnt increments once per rule-3 cycle. Both counters saturate at 16'hFFFF and do not wrap.

## Timing
- While nRST is low, all outputs are forced to 0: every en, flush, pc_en, halt_o, and both counters. The state is RUN.
- Reset asserted mid-DWAIT or mid-HALTED returns the FSM to RUN immediately (asynchronously). Counters clear.
- Control responds in the same cycle. The latch effect appears at the next CLK edge.
- Load-use produces exactly 1 bubble in ID/EX. On the next cycle ex_dREN is 0 (bubble), so the pipeline advances.
- Redirect produces 2 bubbles (IF/ID and ID/EX) and occupies 1 cycle.
- Simultaneous redirect and loaduse: redirect wins, because the dependent instruction is squashed.
- Simultaneous redirect and !ihit: redirect wins, and pc_en=1 so the target is loaded.
- Simultaneous memwait and redirect: the pipe freezes, and the redirect is re-evaluated on the dhit cycle.
- mem_halt during memwait: mem_halt wins. memwb_en=1 latches the halt into WB.

## Test plan
- Reset, then ihit=1 with no hazards: outputs are 0 during reset. After release, pc_en=1 and all en=1; stall_cnt=0.
- Load-use: ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1. Expect pc_en=0, ifid_en=0, idex_flush=1, idex_en=0. stall_cnt 0→1 and flush_cnt unchanged. Next cycle, with ex_dREN=0, full advance.
- D-wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1. Expect 3 cycles of all en=0 with memwb_flush=1 and state DWAIT. On the dhit cycle, full advance; stall_cnt=3.
- Redirect combined with loaduse and !ihit in the same cycle: expect pc_en=1, ifid_flush=idex_flush=1, exmem_en=1. flush_cnt increments by 1.
- Halt: mem_halt=1. Expect memwb_en=1 and other en=0. The next cycle halt_o=1, and it stays 1 for 20 cycles with random inputs while counters are frozen. nRST low then clears halt_o.
- Saturation: force 70000 stall cycles (ihit=0). stall_cnt holds at 16'hFFFF.
